// File: rtl/ipsxe_floating_point_fma_out_double_v1_0_pkg.sv
// Shared definitions for the FMA output stage.
// Holds the IEEE-754 field widths, constant builders for Inf/QNaN words,
// and the bit positions of the per-word and sticky status flags.
package ipsxe_floating_point_fma_out_double_v1_0_pkg;

   localparam int FP64_EXP_WIDTH = 11;
   localparam int FP64_MAN_WIDTH = 52;

   // Per-word flags {invalid, overflow, underflow}; the sticky vector adds fifo_ovf on top.
   localparam int FLAG_UDF       = 0;
   localparam int FLAG_OVF       = 1;
   localparam int FLAG_INV       = 2;
   localparam int FLAG_FOVF      = 3;
   localparam int NUM_WORD_FLAGS = 3;
   localparam int STICKY_W       = 4;

   function automatic logic [63:0] fp64_inf(input logic sign);
      return {sign, {FP64_EXP_WIDTH{1'b1}}, {FP64_MAN_WIDTH{1'b0}}};
   endfunction

   function automatic logic [63:0] fp64_qnan();
      return {1'b0, {FP64_EXP_WIDTH{1'b1}}, 1'b1, {(FP64_MAN_WIDTH-1){1'b0}}};
   endfunction

endpackage

// File: rtl/ipsxe_floating_point_fma_out_double_v1_0_if.sv
// Bus bundle for the FMA output stage.
// slave : the output stage (consumes rounding-stage inputs, drives the AXI-stream side)
// master: the environment (rounding stage, downstream sink, clock-enable controller)
interface ipsxe_floating_point_fma_out_double_v1_0_if #(
   parameter int EXP_WIDTH = 11,
   parameter int MAN_WIDTH = 52,
   parameter int W_USER    = 1
);
   localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH;

   logic              i_aclken;
   logic              i_valid;
   logic [FW-1:0]     i_rounded_float;
   logic              i_underflow;
   logic              i_overflow;
   logic              i_special_valid;
   logic [FW-1:0]     i_special_float;
   logic              i_invalid_op;
   logic [W_USER-1:0] i_user;
   logic              i_tready;
   logic              i_flag_clr;
   logic              o_tvalid;
   logic [FW-1:0]     o_tdata;
   logic [W_USER-1:0] o_tuser;
   logic [2:0]        o_tflags;
   logic              o_afull;
   logic [3:0]        o_sticky_flags;

   modport slave (
      input  i_aclken, i_valid, i_rounded_float, i_underflow, i_overflow,
             i_special_valid, i_special_float, i_invalid_op, i_user, i_tready, i_flag_clr,
      output o_tvalid, o_tdata, o_tuser, o_tflags, o_afull, o_sticky_flags
   );

   modport master (
      output i_aclken, i_valid, i_rounded_float, i_underflow, i_overflow,
             i_special_valid, i_special_float, i_invalid_op, i_user, i_tready, i_flag_clr,
      input  o_tvalid, o_tdata, o_tuser, o_tflags, o_afull, o_sticky_flags
   );
endinterface

// File: rtl/ipsxe_floating_point_fma_out_double_v1_0_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk_i/rst_i; wr_i/din_i write side; rd_i read side (caller guarantees not empty);
// dout_o shows the head word (zero when empty); empty_o; ovf_o flags a write dropped while
// full; cnt_next_o is the occupancy after the current edge.
module ipsxe_floating_point_sync_fifo_fwft_v1_0 #(
   parameter int DATA_W = 8,
   parameter int AW     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              rd_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              empty_o,
   output logic              ovf_o,
   output logic [AW:0]       cnt_next_o
);
   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       cnt_q, cnt_d;
   logic              full, wr_ok, rd_ok;

   assign full    = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign wr_ok   = wr_i & (~full | rd_i);
   assign rd_ok   = rd_i & ~empty_o;
   assign ovf_o   = wr_i & full & ~rd_i;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + CNT_ONE;
      else if (!wr_ok && rd_ok) cnt_d = cnt_q - CNT_ONE;
   end
   assign cnt_next_o = cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din_i;
   end

   // Storage is not reset; gating with empty keeps the output word at zero after reset.
   assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ipsxe_floating_point_fma_out_double_v1_0.sv
// Output stage of the double-precision FMA pipeline.
// A registered select stage merges the rounded word with the special-case path and applies
// overflow saturation / underflow flush; results are buffered in a FWFT FIFO behind an
// AXI-stream valid/ready port. o_afull feeds the pipeline clock-enable controller and
// o_sticky_flags accumulates {fifo_ovf, invalid, overflow, underflow}.
// Ports: i_clk, i_rst (sync, active-high); bus (slave modport) carries all data/handshake.
module ipsxe_floating_point_fma_out_double_v1_0
   import ipsxe_floating_point_fma_out_double_v1_0_pkg::*;
#(
   parameter int EXP_WIDTH    = FP64_EXP_WIDTH,
   parameter int MAN_WIDTH    = FP64_MAN_WIDTH,
   parameter int W_USER       = 1,
   parameter int FIFO_AW      = 4,
   parameter int AFULL_MARGIN = 14
) (
   input logic i_clk,
   input logic i_rst,
   ipsxe_floating_point_fma_out_double_v1_0_if.slave bus
);
   localparam int FW    = 1 + EXP_WIDTH + MAN_WIDTH;
   localparam int DW    = NUM_WORD_FLAGS + W_USER + FW;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] AFULL_TH = (FIFO_AW+1)'(DEPTH - AFULL_MARGIN);

   logic                      sel_vld_q;
   logic [FW-1:0]             sel_word_q, sel_word_d;
   logic [NUM_WORD_FLAGS-1:0] sel_flags_q, sel_flags_d;
   logic [W_USER-1:0]         sel_user_q;
   logic                      afull_q;
   logic [STICKY_W-1:0]       sticky_q, sticky_d, sticky_set;
   logic                      wr, rd, fifo_empty, fifo_ovf;
   logic [FIFO_AW:0]          cnt_next;
   logic [DW-1:0]             fifo_dout;

   // Select: special path overrides everything; overflow saturates to signed Inf,
   // underflow flushes to signed zero. Sign always comes from the rounded word.
   always_comb begin
      sel_word_d            = bus.i_rounded_float;
      sel_flags_d           = '0;
      sel_flags_d[FLAG_INV] = bus.i_invalid_op;
      if (bus.i_special_valid) begin
         sel_word_d = bus.i_special_float;
      end else begin
         sel_flags_d[FLAG_OVF] = bus.i_overflow;
         sel_flags_d[FLAG_UDF] = bus.i_underflow;
         if (bus.i_overflow)
            sel_word_d = {bus.i_rounded_float[FW-1], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
         else if (bus.i_underflow)
            sel_word_d = {bus.i_rounded_float[FW-1], {(FW-1){1'b0}}};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)             sel_vld_q <= 1'b0;
      else if (bus.i_aclken) sel_vld_q <= bus.i_valid;
   end

   always_ff @(posedge i_clk) begin
      if (bus.i_aclken) begin
         sel_word_q  <= sel_word_d;
         sel_flags_q <= sel_flags_d;
         sel_user_q  <= bus.i_user;
      end
   end

   // The select register drains into the FIFO on the same enabled edge that reloads it.
   assign wr = sel_vld_q & bus.i_aclken;
   assign rd = ~fifo_empty & bus.i_tready;

   ipsxe_floating_point_sync_fifo_fwft_v1_0 #(
      .DATA_W (DW),
      .AW     (FIFO_AW)
   ) u_fifo (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .wr_i       (wr),
      .din_i      ({sel_flags_q, sel_user_q, sel_word_q}),
      .rd_i       (rd),
      .dout_o     (fifo_dout),
      .empty_o    (fifo_empty),
      .ovf_o      (fifo_ovf),
      .cnt_next_o (cnt_next)
   );

   // Flags of every write attempt are accumulated, including a dropped one.
   always_comb begin
      sticky_set = '0;
      if (wr) begin
         sticky_set[NUM_WORD_FLAGS-1:0] = sel_flags_q;
         sticky_set[FLAG_FOVF]          = fifo_ovf;
      end
      sticky_d = (bus.i_flag_clr ? '0 : sticky_q) | sticky_set;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         afull_q  <= 1'b0;
         sticky_q <= '0;
      end else begin
         afull_q  <= (cnt_next >= AFULL_TH);
         sticky_q <= sticky_d;
      end
   end

   assign bus.o_tvalid = ~fifo_empty;
   assign {bus.o_tflags, bus.o_tuser, bus.o_tdata} = fifo_dout;
   assign bus.o_afull        = afull_q;
   assign bus.o_sticky_flags = sticky_q;

endmodule

// File: tb/tb_ipsxe_floating_point_fma_out_double_v1_0.sv
module tb_ipsxe_floating_point_fma_out_double_v1_0;
   import ipsxe_floating_point_fma_out_double_v1_0_pkg::*;

   typedef struct packed {
      logic [63:0] data;
      logic        user;
      logic [2:0]  flags;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ipsxe_floating_point_fma_out_double_v1_0_if bus_if ();

   ipsxe_floating_point_fma_out_double_v1_0 dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if)
   );

   int   n_cmp = 0;
   int   n_fail = 0;
   res_t expq[$];

   // Reference model state: pending select word, occupancy, sticky flags, almost-full.
   logic       m_sel_v = 1'b0;
   res_t       m_sel;
   int         mcount = 0;
   logic [3:0] m_sticky = 4'h0;
   logic       m_afull = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t ref_result(input logic [63:0] r, input logic uf, input logic ovf,
                                       input logic sv, input logic [63:0] sf, input logic inv,
                                       input logic u);
      res_t x;
      x.user = u;
      if (sv) begin
         x.data  = sf;
         x.flags = {inv, 2'b00};
      end else begin
         x.flags = {inv, ovf, uf};
         if (ovf)     x.data = fp64_inf(r[63]);
         else if (uf) x.data = {r[63], 63'h0};
         else         x.data = r;
      end
      return x;
   endfunction

   // Model: evaluated on each clock edge from the inputs the bench is presenting.
   always @(posedge clk) begin
      logic       rd;
      logic [3:0] set;
      if (rst) begin
         m_sel_v  = 1'b0;
         mcount   = 0;
         m_sticky = 4'h0;
         m_afull  = 1'b0;
         expq.delete();
      end else begin
         rd  = (mcount > 0) && bus_if.i_tready;
         set = 4'h0;
         if (bus_if.i_aclken && m_sel_v) begin
            set[2:0] = m_sel.flags;
            if (mcount < 16 || rd) begin
               expq.push_back(m_sel);
               mcount++;
            end else begin
               set[3] = 1'b1;
            end
         end
         if (rd) mcount--;
         m_sticky = (bus_if.i_flag_clr ? 4'h0 : m_sticky) | set;
         m_afull  = (mcount >= 2);
         if (bus_if.i_aclken) begin
            m_sel_v = bus_if.i_valid;
            m_sel   = ref_result(bus_if.i_rounded_float, bus_if.i_underflow, bus_if.i_overflow,
                                 bus_if.i_special_valid, bus_if.i_special_float,
                                 bus_if.i_invalid_op, bus_if.i_user);
         end
      end
   end

   // Monitor: compares on the falling edge, pops when the word is consumed.
   always @(negedge clk) begin
      if (!rst) begin
         chk("tvalid", bus_if.o_tvalid, (mcount > 0));
         chk("afull", bus_if.o_afull, m_afull);
         chk("sticky", bus_if.o_sticky_flags, m_sticky);
         if (bus_if.o_tvalid) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_word: got %h expected none", bus_if.o_tdata);
            end else begin
               chk("tdata", bus_if.o_tdata, expq[0].data);
               chk("tuser", bus_if.o_tuser, expq[0].user);
               chk("tflags", bus_if.o_tflags, expq[0].flags);
               if (bus_if.i_tready) void'(expq.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] r, input logic uf, input logic ovf, input logic sv,
                       input logic [63:0] sf, input logic inv, input logic u);
      bus_if.i_valid         = 1'b1;
      bus_if.i_rounded_float = r;
      bus_if.i_underflow     = uf;
      bus_if.i_overflow      = ovf;
      bus_if.i_special_valid = sv;
      bus_if.i_special_float = sf;
      bus_if.i_invalid_op    = inv;
      bus_if.i_user          = u;
      step();
      bus_if.i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus_if.i_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_rand_plain();
      send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'($urandom));
   endtask

   task automatic drain();
      int t = 0;
      bus_if.i_valid  = 1'b0;
      bus_if.i_aclken = 1'b1;
      bus_if.i_tready = 1'b1;
      while ((expq.size() != 0 || mcount != 0 || m_sel_v) && t < 200) begin
         step();
         t++;
      end
      chk("drain_within_budget", (t < 200), 1);
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      chk("rst_tvalid", bus_if.o_tvalid, 0);
      chk("rst_tdata", bus_if.o_tdata, 0);
      chk("rst_tuser", bus_if.o_tuser, 0);
      chk("rst_tflags", bus_if.o_tflags, 0);
      chk("rst_afull", bus_if.o_afull, 0);
      chk("rst_sticky", bus_if.o_sticky_flags, 0);
      step();
   endtask

   initial begin
      bus_if.i_aclken        = 1'b1;
      bus_if.i_valid         = 1'b0;
      bus_if.i_rounded_float = '0;
      bus_if.i_underflow     = 1'b0;
      bus_if.i_overflow      = 1'b0;
      bus_if.i_special_valid = 1'b0;
      bus_if.i_special_float = '0;
      bus_if.i_invalid_op    = 1'b0;
      bus_if.i_user          = '0;
      bus_if.i_tready        = 1'b1;
      bus_if.i_flag_clr      = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      check_reset_state();

      // Plain 1.0, overflow (negative), underflow (positive), special NaN with invalid.
      send(64'h3FF0000000000000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      idle(3);
      send(64'hC123456789ABCDEF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(3);
      send(64'h0000000000000123, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      idle(3);
      bus_if.i_flag_clr = 1'b1;
      step();
      bus_if.i_flag_clr = 1'b0;
      idle(2);
      send(64'h4000000000000000, 1'b0, 1'b1, 1'b1, fp64_qnan(), 1'b1, 1'b1);
      idle(3);

      // Back-pressure: 17 words into a 16-deep FIFO, the last one is dropped.
      bus_if.i_tready = 1'b0;
      for (int i = 0; i < 17; i++) send_rand_plain();
      idle(3);
      drain();

      // Full FIFO, then 20 cycles of simultaneous read and write.
      bus_if.i_tready = 1'b0;
      for (int i = 0; i < 16; i++) send_rand_plain();
      idle(2);
      send_rand_plain();
      bus_if.i_tready = 1'b1;
      for (int i = 0; i < 20; i++) send_rand_plain();
      drain();

      // Randomized traffic with enable gaps, back-pressure and flag clears.
      for (int i = 0; i < 600; i++) begin
         bus_if.i_aclken   = ($urandom_range(0, 9) < 8);
         bus_if.i_tready   = ($urandom_range(0, 9) < 6);
         bus_if.i_flag_clr = ($urandom_range(0, 19) == 0);
         bus_if.i_valid    = ($urandom_range(0, 9) < 7);
         bus_if.i_rounded_float = {$urandom, $urandom};
         bus_if.i_underflow     = ($urandom_range(0, 7) == 0);
         bus_if.i_overflow      = ($urandom_range(0, 7) == 0);
         bus_if.i_special_valid = ($urandom_range(0, 7) == 0);
         bus_if.i_special_float = $urandom_range(0, 1) ? fp64_qnan() : fp64_inf(1'($urandom));
         bus_if.i_invalid_op    = ($urandom_range(0, 7) == 0);
         bus_if.i_user          = 1'($urandom);
         step();
      end
      bus_if.i_flag_clr = 1'b0;
      drain();

      // Reset while words are buffered discards them.
      bus_if.i_tready = 1'b0;
      for (int i = 0; i < 6; i++) send({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_reset_state();
      drain();
      chk("final_queue_empty", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
